zone_alarm_ctrl: RTL and testbench
==================================

Name: zone_alarm_ctrl

Overview:
Parametrised multi-zone alarm controller. Generalises fixed switch-to-LED logic into a clocked state machine with arm/disarm, exit and entry delay counters, per-zone trip latching and code-based disarm. Sits between board switches/sensors and the LED/SEG outputs of the top level; all inputs are treated as already synchronous to clk_2.

Parameters:
NZONES, 6, number of zone sensor inputs
CODE_W, 4, width of disarm code
CODE, 4'h9, disarm code value
EXIT_CYCLES, 8, exit delay length in cycles (>=1)
ENTRY_CYCLES, 4, entry delay length in cycles (>=1)
INSTANT_MASK, 6'b100000, zones that skip entry delay (NZONES bits)
MAX_TRIES, 3, wrong code entries in a delay state before forced ALARM (>=1)
SIREN_CYCLES, 16, siren duration, used only with ALARM_TIMEOUT_EN
CNT_W, localparam, $clog2(max(EXIT_CYCLES,ENTRY_CYCLES,SIREN_CYCLES)+1)

Ports:
clk_2  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
arm  input  1  arm switch, level; its rising edge requests arming
zones  input  NZONES  zone sensors, 1 = tripped
code  input  CODE_W  code switches
code_enter  input  1  code strobe switch; its rising edge submits code
state  output  3  0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 ENTRY_DELAY, 4 ALARM
zone_latch  output  NZONES  sticky record of zones tripped since last arm
siren  output  1  high in ALARM
armed_led  output  1  high in EXIT_DELAY, ARMED, ENTRY_DELAY
countdown  output  CNT_W  remaining delay cycles in delay states, else 0
arm_fault  output  1  one-cycle pulse: arm refused

Behaviour:
- Reset (async, rst_n=0): state=DISARMED, zone_latch=0, siren=0, armed_led=0, countdown=0, arm_fault=0, bad_tries=0; arm/code_enter history registers = 1, so a switch held high through reset produces no edge.
- Edge detect: arm_rise = arm & ~arm_q; code_rise = code_enter & ~code_q; history updated every cycle. valid = code_rise & (code==CODE); wrong = code_rise & (code!=CODE).
- All outputs are registered; they reflect the state and counter after the clock edge on which the transition happens.
- DISARMED: arm_rise & zones==0 -> EXIT_DELAY, cnt=EXIT_CYCLES-1, zone_latch=0, bad_tries=0. arm_rise & zones!=0 -> stay, arm_fault=1 for one cycle. Codes ignored.
- EXIT_DELAY: valid -> DISARMED. Otherwise cnt==0 -> ARMED, else cnt-1. Zones ignored.
- ARMED: valid -> DISARMED (priority over zones). Else if (zones & INSTANT_MASK)!=0 -> ALARM. Else if zones!=0 -> ENTRY_DELAY, cnt=ENTRY_CYCLES-1. zone_latch |= zones on any trip.
- ENTRY_DELAY: zone_latch |= zones every cycle. valid -> DISARMED. wrong: bad_tries+1; at MAX_TRIES -> ALARM immediately. cnt==0 -> ALARM, else cnt-1.
- ALARM: siren=1; zone_latch |= zones; valid -> DISARMED; wrong ignored.
- Entering DISARMED: bad_tries=0, siren=0; zone_latch retained for display until next successful arm.
- countdown = cnt in EXIT_DELAY/ENTRY_DELAY, else 0. No wrap: cnt never decrements below 0.
- Reset asserted mid-delay or in ALARM: immediate return to reset values, no pending edge carried over.

Optional Feature:
ALARM_TIMEOUT_EN: defined -> entering ALARM loads cnt=SIREN_CYCLES-1; cnt decrements in ALARM; at cnt==0 state -> ARMED, siren=0, zone_latch kept; countdown shows cnt in ALARM too; valid still disarms at any time. Undefined -> ALARM holds until valid; SIREN_CYCLES unused, countdown=0 in ALARM.

Test Plan:
- Reset with arm=1 held, release rst_n -> state=0, no transition, arm_fault=0; toggle arm 0->1 with zones=0 -> state=1, countdown=7, armed_led=1.
- Arm with zones=6'b000100 -> state stays 0, arm_fault=1 for exactly one cycle, zone_latch unchanged.
- Armed, pulse zones=6'b000001 for 1 cycle -> state=3, countdown=3 then 2,1,0, then state=4, siren=1, zone_latch=6'b000001.
- ENTRY_DELAY, enter code 4'h3 three times -> state=4 on the third rise; then code 4'h9 -> state=0, siren=0, zone_latch retained.
- ARMED, zones=6'b100000 -> state=4 next cycle (no entry delay); same cycle as valid code -> state=0 instead.
- With ALARM_TIMEOUT_EN: reach ALARM -> siren high exactly 16 cycles, then state=2, siren=0; without macro siren stays high beyond 100 cycles.

Source files
------------

// File: rtl/zone_alarm_ctrl.sv
// Multi-zone alarm controller: arm/disarm FSM with exit/entry delays, zone trip latching and code disarm.
// Optional build macro ALARM_TIMEOUT_EN: ALARM times out after SIREN_CYCLES and returns to ARMED.
module zone_alarm_ctrl #(
    parameter int                NZONES       = 6,
    parameter int                CODE_W       = 4,
    parameter logic [CODE_W-1:0] CODE         = 4'h9,
    parameter int                EXIT_CYCLES  = 8,
    parameter int                ENTRY_CYCLES = 4,
    parameter logic [NZONES-1:0] INSTANT_MASK = 6'b100000,
    parameter int                MAX_TRIES    = 3,
    parameter int                SIREN_CYCLES = 16,
    localparam int CNT_W = $clog2(((((EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES)
                                   > SIREN_CYCLES) ? ((EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES
                                   : ENTRY_CYCLES) : SIREN_CYCLES) + 1)
) (
    input  logic              clk_2,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [NZONES-1:0] zones,
    input  logic [CODE_W-1:0] code,
    input  logic              code_enter,
    output logic [2:0]        state,
    output logic [NZONES-1:0] zone_latch,
    output logic              siren,
    output logic              armed_led,
    output logic [CNT_W-1:0]  countdown,
    output logic              arm_fault
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

`ifdef ALARM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(SIREN_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] ALARM_LOAD = '0;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NZONES-1:0] latch_q, latch_d;
    logic [TRY_W-1:0]  tries_q, tries_d, tries_inc;
    logic              fault_q, fault_d;
    logic              siren_q, siren_d;
    logic              led_q, led_d;
    logic [CNT_W-1:0]  cd_q, cd_d;
    logic              arm_q, code_q;
    logic              arm_rise, code_rise, valid, wrong, show_cnt;

    assign arm_rise  = arm & ~arm_q;
    assign code_rise = code_enter & ~code_q;
    assign valid     = code_rise & (code == CODE);
    assign wrong     = code_rise & (code != CODE);
    assign tries_inc = tries_q + TRY_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        tries_d = tries_q;
        fault_d = 1'b0;
        case (state_q)
            S_DISARMED: begin
                if (arm_rise) begin
                    if (zones == '0) begin
                        state_d = S_EXIT;
                        cnt_d   = CNT_W'(EXIT_CYCLES - 1);
                        latch_d = '0;
                        tries_d = '0;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            S_EXIT: begin
                if (valid)              state_d = S_DISARMED;
                else if (cnt_q == '0)   state_d = S_ARMED;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            S_ARMED: begin
                if (valid) begin
                    state_d = S_DISARMED;
                end else if ((zones & INSTANT_MASK) != '0) begin
                    state_d = S_ALARM;
                    cnt_d   = ALARM_LOAD;
                    latch_d = latch_q | zones;
                end else if (zones != '0) begin
                    state_d = S_ENTRY;
                    cnt_d   = CNT_W'(ENTRY_CYCLES - 1);
                    latch_d = latch_q | zones;
                end
            end
            S_ENTRY: begin
                latch_d = latch_q | zones;
                if (valid) begin
                    state_d = S_DISARMED;
                end else begin
                    if (wrong) tries_d = tries_inc;
                    // Too many wrong codes cuts the entry delay short
                    if ((wrong && tries_inc == TRY_W'(MAX_TRIES)) || cnt_q == '0) begin
                        state_d = S_ALARM;
                        cnt_d   = ALARM_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_ALARM: begin
                latch_d = latch_q | zones;
                if (valid) begin
                    state_d = S_DISARMED;
                end
`ifdef ALARM_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            default: state_d = S_DISARMED;
        endcase
        if (state_d == S_DISARMED) tries_d = '0;
    end

    always_comb begin
        siren_d  = (state_d == S_ALARM);
        led_d    = (state_d == S_EXIT) || (state_d == S_ARMED) || (state_d == S_ENTRY);
        show_cnt = (state_d == S_EXIT) || (state_d == S_ENTRY);
`ifdef ALARM_TIMEOUT_EN
        show_cnt = show_cnt || (state_d == S_ALARM);
`endif
        cd_d     = show_cnt ? cnt_d : '0;
    end

    // History registers reset high so a switch held through reset gives no edge
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DISARMED;
            cnt_q   <= '0;
            latch_q <= '0;
            tries_q <= '0;
            fault_q <= 1'b0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
            cd_q    <= '0;
            arm_q   <= 1'b1;
            code_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            tries_q <= tries_d;
            fault_q <= fault_d;
            siren_q <= siren_d;
            led_q   <= led_d;
            cd_q    <= cd_d;
            arm_q   <= arm;
            code_q  <= code_enter;
        end
    end

    assign state      = state_q;
    assign zone_latch = latch_q;
    assign siren      = siren_q;
    assign armed_led  = led_q;
    assign countdown  = cd_q;
    assign arm_fault  = fault_q;

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// Directed bench for zone_alarm_ctrl; a second instance with a longer entry delay exercises MAX_TRIES.
module tb_zone_alarm_ctrl;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic       arm;
    logic [5:0] zones;
    logic [3:0] code;
    logic       code_enter;

    logic [2:0] state, state2;
    logic [5:0] zone_latch, zone_latch2;
    logic       siren, siren2;
    logic       armed_led, armed_led2;
    logic [4:0] countdown, countdown2;
    logic       arm_fault, arm_fault2;

    int checks   = 0;
    int failures = 0;
    int scount;

    always #5 clk_2 = ~clk_2;

    zone_alarm_ctrl dut (
        .clk_2(clk_2), .rst_n(rst_n), .arm(arm), .zones(zones), .code(code),
        .code_enter(code_enter), .state(state), .zone_latch(zone_latch), .siren(siren),
        .armed_led(armed_led), .countdown(countdown), .arm_fault(arm_fault)
    );

    zone_alarm_ctrl #(.ENTRY_CYCLES(8)) dut2 (
        .clk_2(clk_2), .rst_n(rst_n), .arm(arm), .zones(zones), .code(code),
        .code_enter(code_enter), .state(state2), .zone_latch(zone_latch2), .siren(siren2),
        .armed_led(armed_led2), .countdown(countdown2), .arm_fault(arm_fault2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b1; zones = '0; code = '0; code_enter = 1'b0;
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_latch", zone_latch, 0);
        chk("rst_siren", siren, 0);
        chk("rst_led", armed_led, 0);
        chk("rst_cd", countdown, 0);
        chk("rst_fault", arm_fault, 0);

        rst_n = 1'b1; tick(1);
        chk("held_arm_state", state, 0);
        chk("held_arm_fault", arm_fault, 0);

        arm = 1'b0; tick(1);
        arm = 1'b1; tick(1);
        chk("arm_state", state, 1);
        chk("arm_cd", countdown, 7);
        chk("arm_led", armed_led, 1);

        code = 4'h9; code_enter = 1'b1; tick(1);
        chk("exit_disarm_state", state, 0);
        chk("exit_disarm_cd", countdown, 0);
        code_enter = 1'b0; arm = 1'b0; tick(1);

        // Full exit delay, then entry delay timeout into ALARM
        arm = 1'b1; tick(1);
        chk("arm2_state", state, 1);
        tick(7);
        chk("exit_end_state", state, 1);
        chk("exit_end_cd", countdown, 0);
        tick(1);
        chk("armed_state", state, 2);
        chk("armed_led", armed_led, 1);
        chk("armed_cd", countdown, 0);

        zones = 6'b000001; tick(1);
        zones = '0;
        chk("entry_state", state, 3);
        chk("entry_cd3", countdown, 3);
        chk("entry_latch", zone_latch, 6'b000001);
        tick(1); chk("entry_cd2", countdown, 2);
        tick(1); chk("entry_cd1", countdown, 1);
        tick(1); chk("entry_cd0", countdown, 0);
        chk("entry_cd0_state", state, 3);
        tick(1);
        chk("timeout_alarm", state, 4);
        chk("timeout_siren", siren, 1);
        chk("alarm_led", armed_led, 0);
        chk("alarm_cd", countdown, 0);
        chk("alarm_latch", zone_latch, 6'b000001);

        code = 4'h9; code_enter = 1'b1; tick(1);
        chk("alarm_disarm", state, 0);
        chk("alarm_disarm_siren", siren, 0);
        chk("latch_kept", zone_latch, 6'b000001);
        code_enter = 1'b0; arm = 1'b0; tick(1);

        // Arm refused while a zone is open
        zones = 6'b000100; arm = 1'b1; tick(1);
        chk("fault_state", state, 0);
        chk("fault_pulse", arm_fault, 1);
        chk("fault_latch", zone_latch, 6'b000001);
        tick(1);
        chk("fault_clear", arm_fault, 0);
        chk("fault_state2", state, 0);
        zones = '0; arm = 1'b0; tick(1);

        // Wrong codes during entry delay
        arm = 1'b1; tick(1);
        chk("rearm_state", state, 1);
        chk("rearm_latch_clr", zone_latch, 0);
        tick(8);
        chk("rearm_armed", state, 2);
        chk("rearm_armed2", state2, 2);
        code = 4'h3; zones = 6'b000010; tick(1);
        zones = '0;
        chk("wr_entry", state, 3);
        chk("wr_entry_cd", countdown, 3);
        chk("wr_entry2_cd", countdown2, 7);
        code_enter = 1'b1; tick(1);
        chk("wr1_cd", countdown, 2);
        chk("wr1_cd2", countdown2, 6);
        code_enter = 1'b0; tick(1);
        code_enter = 1'b1; tick(1);
        chk("wr2_state", state, 3);
        chk("wr2_cd", countdown, 0);
        chk("wr2_state2", state2, 3);
        chk("wr2_cd2", countdown2, 4);
        code_enter = 1'b0; tick(1);
        chk("wr_timeout", state, 4);
        chk("wr_pre3_state2", state2, 3);
        chk("wr_pre3_cd2", countdown2, 3);
        code_enter = 1'b1; tick(1);
        chk("wr3_alarm2", state2, 4);
        chk("wr3_siren2", siren2, 1);
        chk("wr3_ignored", state, 4);
        code_enter = 1'b0; tick(1);
        code = 4'h9; code_enter = 1'b1; tick(1);
        chk("wr_disarm", state, 0);
        chk("wr_disarm2", state2, 0);
        chk("wr_disarm_siren", siren, 0);
        chk("wr_latch", zone_latch, 6'b000010);

        // Instant zone skips entry delay
        code_enter = 1'b0; arm = 1'b0; tick(1);
        arm = 1'b1; tick(1);
        tick(8);
        chk("inst_armed", state, 2);
        zones = 6'b100000; tick(1);
        zones = '0;
        chk("inst_alarm", state, 4);
        chk("inst_siren", siren, 1);
        chk("inst_latch", zone_latch, 6'b100000);
        scount = 1;
        for (int i = 0; i < 109; i++) begin
            tick(1);
            if (siren) scount++;
        end
`ifdef ALARM_TIMEOUT_EN
        chk("siren_len", scount, 16);
        chk("timeout_state", state, 2);
        chk("timeout_cd", countdown, 0);
`else
        chk("siren_len", scount, 110);
        chk("hold_state", state, 4);
        chk("hold_cd", countdown, 0);
`endif
        code_enter = 1'b1; tick(1);
        chk("inst_disarm", state, 0);

        // Valid code wins over an instant zone in the same cycle
        code_enter = 1'b0; arm = 1'b0; tick(1);
        arm = 1'b1; tick(9);
        chk("prio_armed", state, 2);
        zones = 6'b100000; code_enter = 1'b1; tick(1);
        chk("prio_state", state, 0);
        chk("prio_siren", siren, 0);
        zones = '0; code_enter = 1'b0; arm = 1'b0; tick(1);

        // Asynchronous reset mid exit delay, arm held high across it
        arm = 1'b1; tick(1);
        chk("pre_rst_state", state, 1);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_cd", countdown, 0);
        chk("async_rst_led", armed_led, 0);
        tick(1);
        rst_n = 1'b1; tick(1);
        chk("post_rst_state", state, 0);
        chk("post_rst_fault", arm_fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
